// File: rtl/bsg_dmc_rst_seq.sv
// DRAM controller reset sequencer: synchronizes the raw async reset, holds ctrl_reset_o, then raises a timed dfi_cke_o.
// Latency: ctrl_reset_o falls S+H edges after release and dfi_cke_o rises C edges later; re-init takes effect one edge after acceptance.
// Backpressure: reinit_ready_o is high only in RUN; requests in HOLD/CKE are dropped. BSG_DMC_RST_SEQ_COUNT_EN adds reinit_count_o.
`timescale 1ns/1ps
module bsg_dmc_rst_seq #(
  parameter int sync_stages_p      = 2,
  parameter int rst_hold_cycles_p  = 16,
  parameter int cke_delay_cycles_p = 32
) (
  input  logic       clk_i,
  input  logic       async_reset_i,
  input  logic       reinit_v_i,
  output logic       reinit_ready_o,
  output logic       ctrl_reset_o,
  output logic       dfi_cke_o,
  output logic       init_done_o
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
  ,
  output logic [7:0] reinit_count_o
`endif
);

  localparam int max_cycles_lp = (rst_hold_cycles_p > cke_delay_cycles_p) ? rst_hold_cycles_p : cke_delay_cycles_p;
  localparam int cnt_w_lp      = (max_cycles_lp > 1) ? $clog2(max_cycles_lp) : 1;
  localparam logic [cnt_w_lp-1:0] hold_last_lp = cnt_w_lp'(rst_hold_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] cke_last_lp  = cnt_w_lp'(cke_delay_cycles_p - 1);

  typedef enum logic [2:0] {
    HOLD = 3'b001,
    CKE  = 3'b010,
    RUN  = 3'b100
  } state_e;

  state_e                state_r, state_n;
  logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
  logic [sync_stages_p-1:0] sync_r;
  logic                  sync_rst;
  logic                  accept;

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) sync_r <= '1;
    else               sync_r <= {sync_r[sync_stages_p-2:0], 1'b0};
  end

  assign sync_rst = sync_r[sync_stages_p-1];

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_r <= HOLD;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      HOLD: begin
        if (sync_rst) begin
          cnt_n = '0;
        end else if (cnt_r == hold_last_lp) begin
          state_n = CKE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      CKE: begin
        if (cnt_r == cke_last_lp) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      RUN: begin
        // The synchronizer stays released, so a re-init only replays H and C.
        if (reinit_v_i) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  assign ctrl_reset_o   = state_r[0];
  assign dfi_cke_o      = state_r[2];
  assign init_done_o    = state_r[2];
  assign reinit_ready_o = state_r[2];
  assign accept         = reinit_v_i & reinit_ready_o;

`ifdef BSG_DMC_RST_SEQ_COUNT_EN
  logic [7:0] reinit_count_r;

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i)                          reinit_count_r <= 8'd0;
    else if (accept && reinit_count_r != 8'hFF) reinit_count_r <= reinit_count_r + 8'd1;
  end

  assign reinit_count_o = reinit_count_r;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_bsg_dmc_rst_seq.sv
// Directed bench for bsg_dmc_rst_seq: default-parameter instance plus an S=2,H=1,C=1 corner instance on a shared reset.
`timescale 1ns/1ps
module tb_bsg_dmc_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reinit_v = 1'b0;
  logic reinit_v_c = 1'b0;
  logic ready, ctrl_rst, cke, done;
  logic ready_c, ctrl_rst_c, cke_c, done_c;
  int   vecs = 0;
  int   errs = 0;
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
  logic [7:0] count, count_c;
`endif

  always #5 clk = ~clk;

  bsg_dmc_rst_seq dut (
    .clk_i          (clk),
    .async_reset_i  (rst),
    .reinit_v_i     (reinit_v),
    .reinit_ready_o (ready),
    .ctrl_reset_o   (ctrl_rst),
    .dfi_cke_o      (cke),
    .init_done_o    (done)
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
    ,
    .reinit_count_o (count)
`endif
  );

  bsg_dmc_rst_seq #(
    .sync_stages_p      (2),
    .rst_hold_cycles_p  (1),
    .cke_delay_cycles_p (1)
  ) dut_c (
    .clk_i          (clk),
    .async_reset_i  (rst),
    .reinit_v_i     (reinit_v_c),
    .reinit_ready_o (ready_c),
    .ctrl_reset_o   (ctrl_rst_c),
    .dfi_cke_o      (cke_c),
    .init_done_o    (done_c)
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
    ,
    .reinit_count_o (count_c)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and sample 1ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pack {ctrl_reset, cke, done, ready} for compact checks.
  function automatic logic [7:0] outs();
    return {4'b0, ctrl_rst, cke, done, ready};
  endfunction

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset_outs", outs(), 8'b1000);
    check("reset_outs_c", {4'b0, ctrl_rst_c, cke_c, done_c, ready_c}, 8'b1000);
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
    check("reset_count", count, 8'd0);
`endif

    // Power-up timing, corner instance checked along the way
    release_rst();
    step(2);
    check("corner_e2_ctrl", {7'b0, ctrl_rst_c}, 8'd1);
    step(1);
    check("corner_e3_ctrl", {7'b0, ctrl_rst_c}, 8'd0);
    check("corner_e3_cke", {7'b0, cke_c}, 8'd0);
    step(1);
    check("corner_e4_outs", {4'b0, ctrl_rst_c, cke_c, done_c, ready_c}, 8'b0111);
    step(13);
    check("pwr_e17_outs", outs(), 8'b1000);
    step(1);
    check("pwr_e18_outs", outs(), 8'b0000);
    step(31);
    check("pwr_e49_outs", outs(), 8'b0000);
    step(1);
    check("pwr_e50_outs", outs(), 8'b0111);

    // Single re-init accepted at edge 51
    reinit_v = 1'b1;
    step(1);
    reinit_v = 1'b0;
    check("reinit_e_outs", outs(), 8'b1000);
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
    check("reinit_count1", count, 8'd1);
`endif
    step(15);
    check("reinit_e15_ctrl", {7'b0, ctrl_rst}, 8'd1);
    step(1);
    check("reinit_e16_ctrl", {7'b0, ctrl_rst}, 8'd0);
    step(31);
    check("reinit_e47_cke", {7'b0, cke}, 8'd0);
    step(1);
    check("reinit_e48_outs", outs(), 8'b0111);

    // Requests held through HOLD/CKE are ignored; first RUN edge accepts
    reinit_v = 1'b1;
    rst = 1'b1;
    #1;
    check("async_assert_outs", outs(), 8'b1000);
    step(3);
    release_rst();
    step(17);
    check("ign_e17_ctrl", {7'b0, ctrl_rst}, 8'd1);
    step(1);
    check("ign_e18_ctrl", {7'b0, ctrl_rst}, 8'd0);
    step(31);
    check("ign_e49_cke", {7'b0, cke}, 8'd0);
    step(1);
    check("ign_e50_outs", outs(), 8'b0111);
    step(1);
    reinit_v = 1'b0;
    check("ign_e51_outs", outs(), 8'b1000);
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
    check("ign_count", count, 8'd1);
`endif
    step(15);
    check("ign_e66_ctrl", {7'b0, ctrl_rst}, 8'd1);
    step(1);
    check("ign_e67_ctrl", {7'b0, ctrl_rst}, 8'd0);

    // Reset mid-sequence in CKE, as a glitch shorter than one cycle
    rst = 1'b1;
    step(2);
    release_rst();
    step(30);
    check("mid_e30_outs", outs(), 8'b0000);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_outs", outs(), 8'b1000);
    check("mid_async_outs_c", {4'b0, ctrl_rst_c, cke_c, done_c, ready_c}, 8'b1000);
    rst = 1'b0;
    step(17);
    check("mid_e17_ctrl", {7'b0, ctrl_rst}, 8'd1);
    step(1);
    check("mid_e18_ctrl", {7'b0, ctrl_rst}, 8'd0);
    step(31);
    check("mid_e49_cke", {7'b0, cke}, 8'd0);
    step(1);
    check("mid_e50_outs", outs(), 8'b0111);

    // Back-to-back requests: one accept per 49 edges, cke high one cycle each
    reinit_v = 1'b1;
    step(1);
    check("b2b_accept_outs", outs(), 8'b1000);
    step(47);
    check("b2b_pre_run_cke", {7'b0, cke}, 8'd0);
    step(1);
    check("b2b_run_cke", {7'b0, cke}, 8'd1);
    step(1);
    check("b2b_retrigger_cke", {7'b0, cke}, 8'd0);
`ifdef BSG_DMC_RST_SEQ_COUNT_EN
    check("b2b_count2", count, 8'd2);
    // Saturation: 298 further accepts
    step(298 * 49);
    check("sat_count", count, 8'd255);
    rst = 1'b1;
    #1;
    check("sat_clear", count, 8'd0);
`endif
    reinit_v = 1'b0;
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
